// File: rtl/dnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dnn_pkg
//  Description : Shared types and helpers for the dnn_sched scheduler slice.
//                Scheduler state encoding, in-flight tag record and the
//                datapath result-width rule.
//  Revision    : 1.0 - initial release
// ============================================================================
package dnn_pkg;

    // Tag id width covers the largest supported requester count (8).
    localparam int C_ID_W = 3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        PAUSED = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic              valid;
        logic [C_ID_W-1:0] id;
    } tag_t;

    // Result width of the 4-4-2 MLP datapath for a given input width.
    function automatic int out_w(input int i_w);
        return i_w + 13;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dnn_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : dnn_sched_if
//  Description : Requester-side bus of the dnn_sched scheduler.
//                req_valid/req_x/req_ready : per-requester vector handshake
//                rsp_valid/rsp_out0/1      : one-hot result pulse + data
//                master = requester pool, slave = scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dnn_sched_if
    import dnn_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int I_W   = 7,
    parameter int OUT_W = out_w(I_W)
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*4*I_W-1:0]  req_x;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic [OUT_W-1:0]       rsp_out0;
    logic [OUT_W-1:0]       rsp_out1;

    modport master (
        output req_valid, req_x,
        input  req_ready, rsp_valid, rsp_out0, rsp_out1
    );

    modport slave (
        input  req_valid, req_x,
        output req_ready, rsp_valid, rsp_out0, rsp_out1
    );
endinterface
`default_nettype wire

// File: rtl/dnn_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first asserted
//                req at or after ptr, wrapping modulo N.
//                req     : request vector
//                ptr     : highest-priority index
//                gnt     : one-hot grant (all zero when nothing requested)
//                gnt_idx : binary index of the grant
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);
    localparam int C_PTR_W = $clog2(N);

    // One extra bit so ptr+k never overflows before the modulo fold.
    logic [C_PTR_W:0] w_pos;
    logic             w_found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = {1'b0, ptr} + (C_PTR_W+1)'(k);
            if (w_pos >= (C_PTR_W+1)'(N)) begin
                w_pos = w_pos - (C_PTR_W+1)'(N);
            end
            if (!w_found && req[w_pos[C_PTR_W-1:0]]) begin
                w_found                  = 1'b1;
                gnt[w_pos[C_PTR_W-1:0]]  = 1'b1;
                gnt_idx                  = w_pos[C_PTR_W-1:0];
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/dnn_sched.sv
`default_nettype none
// ============================================================================
//  Module      : dnn_sched
//  Description : Round-robin scheduler sharing one pipelined MLP datapath
//                among NREQ requesters, with tag tracking and pause/drain.
//                clk, rst          : clock, synchronous active-high reset
//                bus (slave)       : requester handshake and result return
//                dp_x0..3          : registered datapath input vector
//                dp_in_ready       : one-cycle issue strobe
//                dp_out0/1         : datapath results, LAT cycles after strobe
//                cfg_pause         : drain and stop request
//                paused            : idle and stopped
//                inflight          : outstanding job count
//                stat_done         : completed-job counter (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module dnn_sched
    import dnn_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int I_W   = 7,
    parameter int LAT   = 3,
    parameter int OUT_W = out_w(I_W)
) (
    input  logic                        clk,
    input  logic                        rst,
    dnn_sched_if.slave                  bus,
    output logic [I_W-1:0]              dp_x0,
    output logic [I_W-1:0]              dp_x1,
    output logic [I_W-1:0]              dp_x2,
    output logic [I_W-1:0]              dp_x3,
    output logic                        dp_in_ready,
    input  logic [OUT_W-1:0]            dp_out0,
    input  logic [OUT_W-1:0]            dp_out1,
    input  logic                        cfg_pause,
    output logic                        paused,
    output logic [$clog2(NREQ+1)-1:0]   inflight,
    output logic [15:0]                 stat_done
);
    localparam int C_PTR_W = $clog2(NREQ);
    localparam int C_CNT_W = $clog2(NREQ+1);
    localparam int C_VEC_W = 4*I_W;

    sched_state_e          r_state;
    sched_state_e          w_state_nxt;
    logic                  w_run;
    logic                  w_drain_empty;

    logic [NREQ-1:0]       r_pending;
    logic [NREQ-1:0]       w_elig;
    logic [NREQ-1:0]       w_gnt;
    logic [C_PTR_W-1:0]    w_gnt_idx;
    logic [C_PTR_W-1:0]    r_ptr;
    logic                  w_accept;
    logic [C_VEC_W-1:0]    w_sel_x;

    logic [C_VEC_W-1:0]    r_dp_x;
    logic                  r_dp_in_ready;
    tag_t                  r_tag [0:LAT];
    logic [NREQ-1:0]       r_rsp_valid;
    logic [OUT_W-1:0]      r_rsp_out0;
    logic [OUT_W-1:0]      r_rsp_out1;
    logic [15:0]           r_done;
    logic [C_CNT_W-1:0]    w_inflight;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A job retiring this cycle counts as gone, so PAUSED is reached on the
    // edge that ends the final response pulse.
    assign w_drain_empty = ((r_pending & ~r_rsp_valid) == '0);

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (cfg_pause) w_state_nxt = DRAIN;
            DRAIN: begin
                if (!cfg_pause)         w_state_nxt = RUN;
                else if (w_drain_empty) w_state_nxt = PAUSED;
            end
            PAUSED:  if (!cfg_pause) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_run  = (r_state == RUN);
        paused = (r_state == PAUSED);
    end

    // ---------------- Arbitration ----------------
    assign w_elig = bus.req_valid & ~r_pending & {NREQ{w_run}};

    rr_arbiter #(.N(NREQ)) u_arb (
        .req     (w_elig),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign bus.req_ready = w_gnt;
    assign w_accept      = |w_gnt;

    always_comb begin
        w_sel_x = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) w_sel_x = w_sel_x | bus.req_x[i*C_VEC_W +: C_VEC_W];
        end
    end

    // ---------------- Datapath issue ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dp_in_ready <= 1'b0;
            r_dp_x        <= '0;
            r_ptr         <= '0;
        end else begin
            r_dp_in_ready <= w_accept;
            if (w_accept) begin
                r_dp_x <= w_sel_x;
                r_ptr  <= (w_gnt_idx == C_PTR_W'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
            end
        end
    end

    assign dp_in_ready = r_dp_in_ready;
    assign dp_x0       = r_dp_x[0*I_W +: I_W];
    assign dp_x1       = r_dp_x[1*I_W +: I_W];
    assign dp_x2       = r_dp_x[2*I_W +: I_W];
    assign dp_x3       = r_dp_x[3*I_W +: I_W];

    // ---------------- Tag pipeline ----------------
    // Stage LAT is valid in exactly the cycle the datapath presents the
    // matching result; clearing on reset orphans any result still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s <= LAT; s++) r_tag[s] <= '0;
        end else begin
            r_tag[0].valid <= w_accept;
            r_tag[0].id    <= C_ID_W'(w_gnt_idx);
            for (int s = 1; s <= LAT; s++) r_tag[s] <= r_tag[s-1];
        end
    end

    // ---------------- Capture and response ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_out0  <= '0;
            r_rsp_out1  <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (r_tag[LAT].valid) begin
                r_rsp_valid <= NREQ'(1) << r_tag[LAT].id;
                r_rsp_out0  <= dp_out0;
                r_rsp_out1  <= dp_out1;
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_out0  = r_rsp_out0;
    assign bus.rsp_out1  = r_rsp_out1;

    // ---------------- Pending set and statistics ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_done    <= '0;
        end else begin
            r_pending <= (r_pending & ~r_rsp_valid) | w_gnt;
            if (|r_rsp_valid) r_done <= r_done + 16'd1;
        end
    end

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < NREQ; i++) w_inflight = w_inflight + C_CNT_W'(r_pending[i]);
    end

    assign inflight  = w_inflight;
    assign stat_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dnn_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dnn_sched
//  Description : Self-checking bench for dnn_sched with a behavioural MLP
//                datapath (all weights 1) and a transaction-level reference
//                model of arbitration, completion and pause behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dnn_sched;
    import dnn_pkg::*;

    localparam int NREQ  = 4;
    localparam int I_W   = 7;
    localparam int LAT   = 3;
    localparam int OUT_W = out_w(I_W);
    localparam int VW    = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dnn_sched_if #(.NREQ(NREQ), .I_W(I_W), .OUT_W(OUT_W)) bus ();

    logic [I_W-1:0]   dp_x0, dp_x1, dp_x2, dp_x3;
    logic             dp_in_ready;
    logic [OUT_W-1:0] dp_out0, dp_out1;
    logic             cfg_pause = 1'b0;
    logic             paused;
    logic [2:0]       inflight;
    logic [15:0]      stat_done;

    dnn_sched #(.NREQ(NREQ), .I_W(I_W), .LAT(LAT), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .dp_x0(dp_x0), .dp_x1(dp_x1), .dp_x2(dp_x2), .dp_x3(dp_x3),
        .dp_in_ready(dp_in_ready), .dp_out0(dp_out0), .dp_out1(dp_out1),
        .cfg_pause(cfg_pause), .paused(paused), .inflight(inflight),
        .stat_done(stat_done)
    );

    // ---------------- Behavioural datapath: out = 4*ReLU(sum x) ----------------
    bit               force_en = 1'b0;
    logic [OUT_W-1:0] force0 = '0, force1 = '0;
    logic [OUT_W-1:0] st0 [0:LAT-1];
    logic [OUT_W-1:0] st1 [0:LAT-1];

    function automatic logic [OUT_W-1:0] mlp(input logic [4*I_W-1:0] x);
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) s += $signed(x[k*I_W +: I_W]);
        if (s < 0) s = 0;
        return OUT_W'(4*s);
    endfunction

    always @(posedge clk) begin
        st0[0] <= (force_en && dp_in_ready) ? force0 : mlp({dp_x3, dp_x2, dp_x1, dp_x0});
        st1[0] <= (force_en && dp_in_ready) ? force1 : mlp({dp_x3, dp_x2, dp_x1, dp_x0});
        for (int k = 1; k < LAT; k++) begin
            st0[k] <= st0[k-1];
            st1[k] <= st1[k-1];
        end
    end
    assign dp_out0 = st0[LAT-1];
    assign dp_out1 = st1[LAT-1];

    // ---------------- Reference model (transaction level) ----------------
    typedef struct {
        int               due;
        int               id;
        logic [OUT_W-1:0] o0;
        logic [OUT_W-1:0] o1;
    } job_t;

    job_t             m_q[$];
    int               m_ptr  = 0;
    bit [NREQ-1:0]    m_busy = '0;
    int               m_mode = 0;      // 0 running, 1 draining, 2 stopped
    int               m_done = 0;
    logic [OUT_W-1:0] m_out0 = '0, m_out1 = '0;
    logic [4*I_W-1:0] m_dp_x = '0;
    bit               m_strobe = 1'b0;
    int               cyc = 0;

    logic [VW-1:0]    got_v, exp_v;
    logic [NREQ-1:0]  got_ready, got_rsp;
    logic [OUT_W-1:0] got_out0, got_out1;
    logic [4*I_W-1:0] got_dpx;
    logic             got_dpr, got_paused;
    logic [2:0]       got_infl;
    logic [15:0]      got_done;

    int total = 0;
    int bad   = 0;

    // Advance one clock: predict this cycle's outputs, sample the DUT at the
    // falling edge, then apply this cycle's events to the model.
    task automatic step();
        int               w, hit;
        logic [NREQ-1:0]  e_ready, e_rsp;
        logic [OUT_W-1:0] e0, e1;
        logic [4*I_W-1:0] x;
        @(negedge clk);
        w = -1;
        if (m_mode == 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (w < 0 && bus.req_valid[i] && !m_busy[i]) w = i;
            end
        end
        e_ready = (w >= 0) ? (NREQ'(1) << w) : '0;
        hit = -1;
        foreach (m_q[j]) if (m_q[j].due == cyc) hit = j;
        e_rsp = '0; e0 = m_out0; e1 = m_out1;
        if (hit >= 0) begin
            e_rsp = NREQ'(1) << m_q[hit].id;
            e0 = m_q[hit].o0;
            e1 = m_q[hit].o1;
        end
        exp_v = VW'({e_ready, e_rsp, e0, e1, m_strobe, m_dp_x,
                     3'($countones(m_busy)), (m_mode == 2), 16'(m_done)});
        got_ready = bus.req_ready; got_rsp = bus.rsp_valid;
        got_out0 = bus.rsp_out0; got_out1 = bus.rsp_out1;
        got_dpr = dp_in_ready; got_dpx = {dp_x3, dp_x2, dp_x1, dp_x0};
        got_infl = inflight; got_paused = paused; got_done = stat_done;
        got_v = VW'({got_ready, got_rsp, got_out0, got_out1, got_dpr, got_dpx,
                     got_infl, got_paused, got_done});
        if (rst) begin
            m_q.delete(); m_ptr = 0; m_busy = '0; m_mode = 0; m_done = 0;
            m_out0 = '0; m_out1 = '0; m_dp_x = '0; m_strobe = 1'b0;
        end else begin
            m_strobe = (w >= 0);
            if (w >= 0) begin
                x = bus.req_x[w*4*I_W +: 4*I_W];
                m_dp_x = x;
                m_busy[w] = 1'b1;
                m_ptr = (w + 1) % NREQ;
                m_q.push_back('{cyc + LAT + 2, w,
                                force_en ? force0 : mlp(x),
                                force_en ? force1 : mlp(x)});
            end
            if (hit >= 0) begin
                m_busy[m_q[hit].id] = 1'b0;
                m_done = (m_done + 1) % 65536;
                m_out0 = e0; m_out1 = e1;
                m_q.delete(hit);
            end
            case (m_mode)
                0: if (cfg_pause) m_mode = 1;
                1: if (!cfg_pause) m_mode = 0; else if (m_busy == '0) m_mode = 2;
                default: if (!cfg_pause) m_mode = 0;
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; cfg_pause = 1'b0; force_en = 1'b0;
        bus.req_valid = '0; bus.req_x = '0;
        step(); step();
        rst = 1'b0;
    endtask

    // ---------------- Scenarios ----------------
    task automatic test_reset();
        do_reset();
        step();
        total++; if (got_v !== '0) begin bad++; $display("FAIL reset_state got=%h exp=0", got_v); end
        total++; if (got_v !== exp_v) begin bad++; $display("FAIL model_reset got=%h exp=%h", got_v, exp_v); end
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            bus.req_valid = (c == 2) ? 4'b0001 : 4'b0000;
            if (c == 2) bus.req_x[27:0] = {7'd4, 7'd3, 7'd2, 7'd1};
            step();
            total++; if (got_v !== exp_v) begin bad++; $display("FAIL model_single c=%0d got=%h exp=%h", c, got_v, exp_v); end
            if (c == 2) begin total++; if (got_ready !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", got_ready); end end
            if (c == 3) begin total++; if (!got_dpr || got_dpx !== {7'd4, 7'd3, 7'd2, 7'd1}) begin bad++; $display("FAIL single_issue got=%b/%h exp=1/%h", got_dpr, got_dpx, {7'd4, 7'd3, 7'd2, 7'd1}); end end
            if (c == 7) begin total++; if (got_rsp !== 4'b0001 || got_out0 !== 20'd40 || got_out1 !== 20'd40) begin bad++; $display("FAIL single_rsp got=%b/%0d/%0d exp=0001/40/40", got_rsp, got_out0, got_out1); end end
            if (c == 8) begin total++; if (got_done !== 16'd1) begin bad++; $display("FAIL single_done got=%0d exp=1", got_done); end end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int c = 0; c < 16; c++) begin
            bus.req_valid = (c == 2) ? 4'b0110 : (c == 3) ? 4'b0100 : (c == 10) ? 4'b1111 : 4'b0000;
            if (c == 2) bus.req_x = 112'($urandom) << 28 | 112'($urandom) << 56;
            step();
            total++; if (got_v !== exp_v) begin bad++; $display("FAIL model_rr c=%0d got=%h exp=%h", c, got_v, exp_v); end
            if (c == 2)  begin total++; if (got_ready !== 4'b0010) begin bad++; $display("FAIL rr_grant1 got=%b exp=0010", got_ready); end end
            if (c == 3)  begin total++; if (got_ready !== 4'b0100) begin bad++; $display("FAIL rr_grant2 got=%b exp=0100", got_ready); end end
            if (c == 7)  begin total++; if (got_rsp !== 4'b0010) begin bad++; $display("FAIL rr_rsp1 got=%b exp=0010", got_rsp); end end
            if (c == 8)  begin total++; if (got_rsp !== 4'b0100) begin bad++; $display("FAIL rr_rsp2 got=%b exp=0100", got_rsp); end end
            if (c == 10) begin total++; if (got_ready !== 4'b1000) begin bad++; $display("FAIL rr_ptr3 got=%b exp=1000", got_ready); end end
        end
    endtask

    task automatic test_full_rate();
        do_reset();
        for (int c = 0; c < 18; c++) begin
            bus.req_valid = (c >= 2 && c <= 8) ? 4'b1111 : 4'b0000;
            if (c == 2) bus.req_x = {$urandom, $urandom, $urandom, $urandom};
            step();
            total++; if (got_v !== exp_v) begin bad++; $display("FAIL model_full c=%0d got=%h exp=%h", c, got_v, exp_v); end
            if (c >= 2 && c <= 5) begin total++; if (got_ready !== (4'b0001 << (c - 2))) begin bad++; $display("FAIL full_grant c=%0d got=%b exp=%b", c, got_ready, 4'b0001 << (c - 2)); end end
            if (c == 6) begin total++; if (got_infl !== 3'd4 || got_ready !== 4'b0000) begin bad++; $display("FAIL full_busy got=%0d/%b exp=4/0000", got_infl, got_ready); end end
            if (c == 7) begin total++; if (got_rsp !== 4'b0001 || got_ready !== 4'b0000) begin bad++; $display("FAIL full_rsp0 got=%b/%b exp=0001/0000", got_rsp, got_ready); end end
            if (c == 8) begin total++; if (got_ready !== 4'b0001) begin bad++; $display("FAIL full_regrant got=%b exp=0001", got_ready); end end
        end
    endtask

    task automatic test_relu_sign();
        do_reset();
        for (int c = 0; c < 18; c++) begin
            bus.req_valid = (c == 2) ? 4'b0001 : (c == 10) ? 4'b0010 : 4'b0000;
            if (c == 2)  bus.req_x[27:0] = {4{7'h7B}};
            if (c == 10) begin
                bus.req_x[55:28] = 28'($urandom);
                force0 = OUT_W'(-100); force1 = OUT_W'(333); force_en = 1'b1;
            end
            if (c == 12) force_en = 1'b0;
            step();
            total++; if (got_v !== exp_v) begin bad++; $display("FAIL model_relu c=%0d got=%h exp=%h", c, got_v, exp_v); end
            if (c == 7)  begin total++; if (got_rsp !== 4'b0001 || got_out0 !== 20'd0 || got_out1 !== 20'd0) begin bad++; $display("FAIL relu_neg got=%b/%h/%h exp=0001/0/0", got_rsp, got_out0, got_out1); end end
            if (c == 15) begin total++; if (got_rsp !== 4'b0010 || got_out0 !== 20'hFFF9C || got_out1 !== 20'd333) begin bad++; $display("FAIL sign_pass got=%b/%h/%h exp=0010/fff9c/14d", got_rsp, got_out0, got_out1); end end
        end
    endtask

    task automatic test_drain();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            bus.req_valid = (c == 2) ? 4'b0011 : (c == 3) ? 4'b0010 : (c >= 5 && c <= 13) ? 4'b0100 : 4'b0000;
            if (c == 2) bus.req_x = {$urandom, $urandom, $urandom, $urandom};
            cfg_pause = (c >= 4 && c <= 11);
            step();
            total++; if (got_v !== exp_v) begin bad++; $display("FAIL model_drain c=%0d got=%h exp=%h", c, got_v, exp_v); end
            if (c >= 4 && c <= 12) begin total++; if (got_ready !== 4'b0000) begin bad++; $display("FAIL drain_nogrant c=%0d got=%b exp=0000", c, got_ready); end end
            if (c == 8)  begin total++; if (got_rsp !== 4'b0010 || got_paused !== 1'b0) begin bad++; $display("FAIL drain_last got=%b/%b exp=0010/0", got_rsp, got_paused); end end
            if (c == 9)  begin total++; if (got_paused !== 1'b1 || got_infl !== 3'd0) begin bad++; $display("FAIL drain_paused got=%b/%0d exp=1/0", got_paused, got_infl); end end
            if (c == 13) begin total++; if (got_ready !== 4'b0100) begin bad++; $display("FAIL drain_resume got=%b exp=0100", got_ready); end end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 16; c++) begin
            bus.req_valid = (c == 2) ? 4'b0001 : 4'b0000;
            if (c == 2) bus.req_x[27:0] = {4{7'd9}};
            rst = (c == 4);
            step();
            total++; if (got_v !== exp_v) begin bad++; $display("FAIL model_rstmid c=%0d got=%h exp=%h", c, got_v, exp_v); end
            if (c >= 5) begin total++; if (got_rsp !== 4'b0000 || got_infl !== 3'd0 || got_done !== 16'd0) begin bad++; $display("FAIL rstmid_drop c=%0d got=%b/%0d/%0d exp=0000/0/0", c, got_rsp, got_infl, got_done); end end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) begin
                    bus.req_valid[i] = 1'b1;
                    bus.req_x[i*4*I_W +: 4*I_W] = (4*I_W)'($urandom);
                end
            end
            if ($urandom_range(0, 40) == 0) cfg_pause = ~cfg_pause;
            rst = ($urandom_range(0, 300) == 0);
            step();
            total++; if (got_v !== exp_v) begin bad++; $display("FAIL model_random c=%0d got=%h exp=%h", c, got_v, exp_v); end
            for (int i = 0; i < NREQ; i++) begin
                if (got_ready[i]) begin
                    bus.req_valid[i] = 1'($urandom_range(0, 1));
                    bus.req_x[i*4*I_W +: 4*I_W] = (4*I_W)'($urandom);
                end
            end
        end
        rst = 1'b0; cfg_pause = 1'b0; bus.req_valid = '0;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_x     = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_full_rate();
        test_relu_sign();
        test_drain();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
